is_psum_drain: RTL
==================

// Module: is_psum_drain
// PURPOSE
//  Drain-side collector for the input-stationary systolic array. It receives the partial sums
//  that leave the bottom PE of each of COLS columns. Column j arrives skewed by j cycles, so the
//  block de-skews them into aligned output rows and buffers the rows in a DEPTH-entry FIFO. It
//  then streams each row out on a valid/ready interface. A small FSM counts the TILE_LEN rows of
//  one tile and signals completion.
// PARAMETERS
//  COLS       4   number of array columns (row width in psums)
//  WIDTH_MAC  48  psum width per column
//  DEPTH      8   FIFO depth in rows; power of 2, >= 2
//  CNT_W      16  width of tile_len and the row counters
// PORTS
//  clk            in   1               clock, all flops on rising edge
//  rst            in   1               asynchronous, active-high reset
//  clear          in   1               synchronous clear of all state (same effect as rst)
//  start          in   1               1-cycle pulse, begin a tile; latches tile_len
//  tile_len       in   CNT_W           rows expected in this tile (0 = DONE right after start)
//  psum_in        in   COLS*WIDTH_MAC  column j on bits [j*WIDTH_MAC +: WIDTH_MAC]
//  psum_vld       in   COLS            per-column valid; column j's row k arrives j cycles after column 0's
//  out_data       out  COLS*WIDTH_MAC  head-of-FIFO row, same column packing
//  out_valid      out  1               FIFO non-empty
//  out_ready      in   1               consumer accepts when out_valid && out_ready
//  almost_full    out  1               FIFO occupancy >= DEPTH-COLS (upstream must stop issuing)
//  busy           out  1               FSM not in IDLE
//  done           out  1               1-cycle pulse when a tile is fully drained
//  err_ovf        out  1               sticky: aligned row dropped because FIFO full
//  err_skew       out  1               sticky: aligned valids were partial (not all-0, not all-1)
// BEHAVIOUR
//  Reset/clear: all outputs 0; FIFO empty; FSM = IDLE; delay lines hold zeros and valid 0.
//  De-skew
//   - Column j passes through (COLS-1-j) register stages, data and valid together.
//   - Column COLS-1 has 0 stages, so all columns align on the cycle column COLS-1 arrives.
//  Row write (per cycle)
//   - All aligned valids = 1 -> row complete.
//   - Partial valids -> row discarded, err_skew set.
//   - Complete row in COLLECT with FIFO not full -> written; rows_in increments.
//   - FIFO full and no pop this cycle -> row dropped, err_ovf set, rows_in still increments.
//     Tile completion is therefore not blocked by a drop.
//   - FIFO full with a pop in the same cycle -> write accepted.
//   - Complete row arriving in IDLE/DRAIN/DONE -> discarded, err_skew set.
//  Latency: column COLS-1 data at cycle t -> row written on edge t -> out_valid = 1 in cycle t+1.
//  FIFO
//   - Show-ahead: out_data is valid whenever out_valid = 1.
//   - Pop on out_valid && out_ready; no pop when empty.
//   - Pointers wrap modulo DEPTH; full/empty come from an occupancy counter (0..DEPTH).
//   - out_data, out_valid and almost_full are driven from registers or the FIFO array,
//     never combinationally from psum_in.
//  FSM (IDLE, COLLECT, DRAIN, DONE)
//   - IDLE -> COLLECT on start: latch tile_len, rows_in = 0.
//     If tile_len = 0, go directly to DONE instead.
//   - COLLECT -> DRAIN when rows_in reaches tile_len (checked after this cycle's write).
//   - DRAIN -> DONE when FIFO occupancy becomes 0.
//   - DONE -> IDLE unconditionally; done = 1 only while in DONE.
//   - start while busy is ignored.
//  err_ovf and err_skew clear only on rst or clear.
//  Reset or clear mid-tile: everything abandoned immediately; next cycle is IDLE with an empty FIFO.
// TESTING  (COLS=4, WIDTH_MAC=16, DEPTH=4)
//  1. Basic de-skew
//     Stimulus: start, tile_len=1; col j drives 16'h0010+j with vld at cycles 5+j.
//     Required: out_valid=1 at cycle 9 with out_data={16'h0013,16'h0012,16'h0011,16'h0010};
//     pop at cycle 9; done pulses at cycle 11.
//  2. Streaming
//     Stimulus: tile_len=3; rows 1,2,3 back-to-back, skewed; out_ready held 1.
//     Required: three consecutive out_valid beats in order; done pulses once.
//  3. Overflow
//     Stimulus: tile_len=6; out_ready=0; 6 rows streamed in.
//     Required: almost_full=1 once occupancy >= 0 (always, since DEPTH=COLS); 4 rows stored;
//     err_ovf=1; after ready=1, 4 beats then done.
//  4. Push+pop at full
//     Stimulus: FIFO full; new row completes in the same cycle as a pop.
//     Required: row accepted; occupancy stays 4; err_ovf stays 0.
//  5. Skew error
//     Stimulus: col 2 vld delayed by one extra cycle.
//     Required: err_skew=1; no write for that row.
//  6. Mid-tile clear
//     Stimulus: clear after 2 of 4 rows.
//     Required: next cycle busy=0, out_valid=0, errors 0; a new start proceeds normally.

Source files
------------

// File: rtl/is_psum_drain_if.sv
// Psum ingress and row egress bundle for the drain collector.
interface is_psum_drain_if #(
  parameter int COLS      = 4,
  parameter int WIDTH_MAC = 48
);
  logic [COLS*WIDTH_MAC-1:0] psum_in;
  logic [COLS-1:0]           psum_vld;
  logic [COLS*WIDTH_MAC-1:0] out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output psum_in, psum_vld, out_ready,
    input  out_data, out_valid
  );
  modport slave (
    input  psum_in, psum_vld, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/is_psum_drain.sv
// De-skews array column psums into rows, buffers them and streams
// each row out; an FSM tracks the rows of one tile.
module is_psum_drain #(
  parameter int COLS      = 4,
  parameter int WIDTH_MAC = 48,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] tile_len,
  is_psum_drain_if.slave   io,
  output logic             almost_full,
  output logic             busy,
  output logic             done,
  output logic             err_ovf,
  output logic             err_skew
);
  localparam int RW = COLS*WIDTH_MAC;
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE, COLLECT, DRAIN, DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH_MAC-1:0] al_d [COLS];
  logic [COLS-1:0]      al_v;
  logic [RW-1:0]        al_row;

  // Column j waits COLS-1-j cycles so all columns meet the last one.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int NS = COLS-1-j;
    if (NS == 0) begin : g_pass
      assign al_d[j] = io.psum_in[j*WIDTH_MAC +: WIDTH_MAC];
      assign al_v[j] = io.psum_vld[j];
    end else begin : g_dly
      logic [WIDTH_MAC-1:0] sd [NS];
      logic [NS-1:0]        sv;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < NS; s++) sd[s] <= '0;
          sv <= '0;
        end else if (clear) begin
          for (int s = 0; s < NS; s++) sd[s] <= '0;
          sv <= '0;
        end else begin
          sd[0] <= io.psum_in[j*WIDTH_MAC +: WIDTH_MAC];
          sv[0] <= io.psum_vld[j];
          for (int s = 1; s < NS; s++) begin
            sd[s] <= sd[s-1];
            sv[s] <= sv[s-1];
          end
        end
      end
      assign al_d[j] = sd[NS-1];
      assign al_v[j] = sv[NS-1];
    end
  end

  always_comb begin
    al_row = '0;
    for (int j = 0; j < COLS; j++)
      al_row[j*WIDTH_MAC +: WIDTH_MAC] = al_d[j];
  end

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [OW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] len_q, rows_in, rows_nxt;
  logic             complete, partial, in_col;
  logic             full, pop, push, wr_ok;

  assign complete = &al_v;
  assign partial  = (|al_v) && !complete;
  assign in_col   = state == COLLECT;
  assign full     = cnt == OW'(DEPTH);
  assign pop      = io.out_valid && io.out_ready;
  assign wr_ok    = complete && in_col;
  assign push     = wr_ok && (!full || pop);
  assign rows_nxt = rows_in + CNT_W'(wr_ok);

  assign io.out_valid = cnt != '0;
  assign io.out_data  = io.out_valid ? mem[rp] : '0;
  assign busy         = state != IDLE;
  assign done         = state == DONE;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + OW'(1);
    else if (pop && !push) cnt_nxt = cnt - OW'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start)
          state_nxt = (tile_len == '0) ? DONE : COLLECT;
      COLLECT:
        if (rows_nxt == len_q) state_nxt = DRAIN;
      DRAIN:
        if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      rows_in     <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      almost_full <= 1'b0;
      err_ovf     <= 1'b0;
      err_skew    <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      len_q       <= '0;
      rows_in     <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      almost_full <= 1'b0;
      err_ovf     <= 1'b0;
      err_skew    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        len_q   <= tile_len;
        rows_in <= '0;
      end else if (wr_ok) begin
        rows_in <= rows_nxt;
      end
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt         <= cnt_nxt;
      almost_full <= int'(cnt_nxt) >= DEPTH-COLS;
      // A dropped row still counts so the tile can finish.
      if (wr_ok && full && !pop) err_ovf <= 1'b1;
      if (partial || (complete && !in_col)) err_skew <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp] <= al_row;
  end
endmodule
